horner_seq_ctrl: RTL and testbench

Sequencer for the feedback polynomial datapath (pipelined adder and multiplier in a loop, result register loaded by `LD_result`). It holds up to eight coefficients, captures an evaluation point on `start`, and evaluates p(x) = c_deg·x^deg + … + c_0 by Horner's rule. It does this by driving `signal`, `coeff` and `LD_result` into the datapath with cycle-exact alignment, then reports completion with `busy`/`done`. It performs no arithmetic itself; operand encoding is whatever the datapath units consume (IEEE-754 single at WIDTH=32).

---
 rtl/horner_seq_ctrl_if.sv | 30 +++
 rtl/horner_seq_ctrl.sv | 161 ++++++++++++++++
 tb/tb_horner_seq_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/horner_seq_ctrl_if.sv
// Bus between the Horner sequencer and its host/datapath.
// Host side: start/degree/x_in and the coefficient write port.
// Datapath side: signal/coeff/LD_result. Status: busy/done.
interface horner_seq_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       degree;
    logic [WIDTH-1:0] x_in;
    logic             coef_we;
    logic [2:0]       coef_addr;
    logic [WIDTH-1:0] coef_wdata;
    logic [WIDTH-1:0] signal;
    logic [WIDTH-1:0] coeff;
    logic             LD_result;
    logic             busy;
    logic             done;

    // Host / environment side
    modport master (
        output start, degree, x_in, coef_we, coef_addr, coef_wdata,
        input  signal, coeff, LD_result, busy, done
    );

    // Sequencer side
    modport slave (
        input  start, degree, x_in, coef_we, coef_addr, coef_wdata,
        output signal, coeff, LD_result, busy, done
    );
endinterface

// File: rtl/horner_seq_ctrl.sv
// Horner-rule sequencer for a feedback add/multiply loop.
// Holds eight coefficients, captures degree and evaluation point on start,
// then steers signal/coeff into the datapath so that each loop slot sees
// c_N, c_(N-1), ..., c_0 at the right time, pulsing LD_result once the
// final sum is valid. All state moves on the falling edge of clk_n.
module horner_seq_ctrl #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned ADD_LAT = 3
) (
    input  logic                clk_n,
    input  logic                rst_n,
    horner_seq_ctrl_if.slave    bus
);

    // Loop period: multiplier, adder and the two register stages between them.
    localparam int unsigned S        = MUL_LAT + ADD_LAT + 2;
    localparam int unsigned PrimeLen = 2 * S;
    localparam int unsigned CntW     = $clog2(PrimeLen);

    localparam logic [CntW-1:0] CntOne     = CntW'(1);
    localparam logic [CntW-1:0] PrimeLast  = CntW'(PrimeLen - 1);
    localparam logic [CntW-1:0] PrimeLdCnt = CntW'(PrimeLen - 2);
    localparam logic [CntW-1:0] RunLast    = CntW'(S - 1);
    // Coefficient steps land MUL_LAT+1 cycles into each loop period.
    localparam logic [CntW-1:0] RunStep    = CntW'(MUL_LAT);
    // In FINISH the counter starts at 0 in the first cycle coeff = c_0.
    localparam logic [CntW-1:0] FinLd      = CntW'(ADD_LAT);
    localparam logic [CntW-1:0] FinDone    = CntW'(ADD_LAT + 1);
    localparam logic [CntW-1:0] FinExit    = CntW'(ADD_LAT + 2);

    typedef enum logic [1:0] {
        StIdle,
        StPrime,
        StRun,
        StFinish
    } state_e;

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [2:0]       step_q;
    logic [2:0]       n_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] signal_q;
    logic [WIDTH-1:0] coeff_q;
    logic             ld_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] coef_q [8];

    // Coefficient file: host writes accepted only while idle.
    always_ff @(negedge clk_n or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                coef_q[i] <= '0;
            end
        end else if (bus.coef_we && !busy_q) begin
            coef_q[bus.coef_addr] <= bus.coef_wdata;
        end
    end

    // Sequencer FSM with registered datapath/status outputs.
    always_ff @(negedge clk_n or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            step_q   <= '0;
            n_q      <= '0;
            x_q      <= '0;
            signal_q <= '0;
            coeff_q  <= '0;
            ld_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            ld_q   <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    signal_q <= '0;
                    coeff_q  <= '0;
                    busy_q   <= 1'b0;
                    cnt_q    <= '0;
                    if (bus.start) begin
                        n_q     <= bus.degree;
                        x_q     <= bus.x_in;
                        coeff_q <= coef_q[bus.degree];
                        busy_q  <= 1'b1;
                        state_q <= StPrime;
                    end
                end
                // Multiplier input held at 0 so every loop slot settles to c_N.
                StPrime: begin
                    if (cnt_q == PrimeLast) begin
                        signal_q <= x_q;
                        if (n_q == 3'd0) begin
                            // Degree 0: the loop already holds c_0; just finish.
                            cnt_q   <= FinExit;
                            done_q  <= 1'b1;
                            state_q <= StFinish;
                        end else begin
                            cnt_q   <= '0;
                            step_q  <= n_q - 3'd1;
                            state_q <= StRun;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                        ld_q  <= (n_q == 3'd0) && (cnt_q == PrimeLdCnt);
                    end
                end
                // One coefficient step per loop period, down to c_0.
                StRun: begin
                    cnt_q <= (cnt_q == RunLast) ? '0 : cnt_q + CntOne;
                    if (cnt_q == RunStep) begin
                        coeff_q <= coef_q[step_q];
                        if (step_q == 3'd0) begin
                            cnt_q   <= '0;
                            state_q <= StFinish;
                        end else begin
                            step_q <= step_q - 3'd1;
                        end
                    end
                end
                // Wait for the last sum to leave the adder, load it, then report.
                StFinish: begin
                    cnt_q <= cnt_q + CntOne;
                    if (cnt_q == FinLd) begin
                        ld_q <= 1'b1;
                    end
                    if (cnt_q == FinDone) begin
                        done_q <= 1'b1;
                    end
                    if (cnt_q == FinExit) begin
                        signal_q <= '0;
                        coeff_q  <= '0;
                        busy_q   <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.signal    = signal_q;
    assign bus.coeff     = coeff_q;
    assign bus.LD_result = ld_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

    // Structural invariants of the sequencer.
    a_done_busy : assert property (@(negedge clk_n) disable iff (!rst_n) done_q |-> busy_q);
    a_ld_busy   : assert property (@(negedge clk_n) disable iff (!rst_n) ld_q |-> busy_q);
    a_ld_done   : assert property (@(negedge clk_n) disable iff (!rst_n) !(ld_q && done_q));
    a_idle_quiet: assert property (@(negedge clk_n) disable iff (!rst_n)
                                  (state_q == StIdle) |-> !(ld_q || done_q));

endmodule

// File: tb/tb_horner_seq_ctrl.sv
// Self-checking bench for horner_seq_ctrl. Each evaluation pushes a
// cycle-by-cycle expected trace (built from the timing formulas) into a
// scoreboard that is popped and compared as the cycles go by.
module tb_horner_seq_ctrl;

    localparam int unsigned W  = 32;
    localparam int unsigned ML = 3;
    localparam int unsigned AL = 3;
    localparam int          S  = ML + AL + 2;
    localparam int          P  = 2 * S + 1;

    logic clk_n = 1'b1;
    logic rst_n;

    horner_seq_ctrl_if #(.WIDTH(W)) bus ();

    horner_seq_ctrl #(
        .WIDTH  (W),
        .MUL_LAT(ML),
        .ADD_LAT(AL)
    ) dut (
        .clk_n(clk_n),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk_n = ~clk_n;

    typedef struct {
        int          cyc;
        logic [31:0] sig;
        logic [31:0] cf;
        logic        ld;
        logic        dn;
        logic        bsy;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] shadow [8];
    int          cyc;
    int          n_checks;
    int          n_fail;
    int          done_seen;
    string       scen;

    // Advance one cycle; sample outputs mid-cycle and check any due entry.
    task automatic tick();
        exp_t e;
        @(posedge clk_n);
        cyc++;
        if (bus.done === 1'b1) done_seen++;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s sb_missed: entry for cycle %0d not checked, now %0d",
                     scen, sb[0].cyc, cyc);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            n_checks += 5;
            if (bus.signal !== e.sig) begin
                n_fail++;
                $display("FAIL %s signal @%0d: got %h expected %h", scen, cyc, bus.signal, e.sig);
            end
            if (bus.coeff !== e.cf) begin
                n_fail++;
                $display("FAIL %s coeff @%0d: got %h expected %h", scen, cyc, bus.coeff, e.cf);
            end
            if (bus.LD_result !== e.ld) begin
                n_fail++;
                $display("FAIL %s LD_result @%0d: got %b expected %b", scen, cyc,
                         bus.LD_result, e.ld);
            end
            if (bus.done !== e.dn) begin
                n_fail++;
                $display("FAIL %s done @%0d: got %b expected %b", scen, cyc, bus.done, e.dn);
            end
            if (bus.busy !== e.bsy) begin
                n_fail++;
                $display("FAIL %s busy @%0d: got %b expected %b", scen, cyc, bus.busy, e.bsy);
            end
        end
    endtask

    // Expected trace for an evaluation whose start is sampled at cycle base.
    function automatic int push_eval(int base, int n, logic [31:0] x);
        int   ldc, dnc, c0, k, idx;
        exp_t e;
        if (n == 0) begin
            ldc = 2 * S;
            dnc = 2 * S + 1;
        end else begin
            c0  = P + ML + 1 + (n - 1) * S;
            ldc = c0 + AL + 1;
            dnc = ldc + 1;
        end
        for (int t = 1; t <= dnc + 1; t++) begin
            e.cyc = base + t;
            e.bsy = (t <= dnc);
            e.ld  = (t == ldc);
            e.dn  = (t == dnc);
            e.sig = (t >= P && t <= dnc) ? x : 32'h0;
            if (t > dnc) begin
                e.cf = 32'h0;
            end else if (n == 0 || t < P + ML + 1) begin
                e.cf = shadow[n];
            end else begin
                k   = (t - (P + ML + 1)) / S;
                idx = n - 1 - k;
                if (idx < 0) idx = 0;
                e.cf = shadow[idx];
            end
            sb.push_back(e);
        end
        return base + dnc + 1;
    endfunction

    task automatic start_eval(input int n, input logic [31:0] x, output int end_cyc);
        bus.start  = 1'b1;
        bus.degree = n[2:0];
        bus.x_in   = x;
        end_cyc    = push_eval(cyc, n, x);
        tick();
        bus.start  = 1'b0;
        bus.degree = 3'($urandom);
        bus.x_in   = $urandom;
    endtask

    // Run until the idle cycle after done and confirm the trace was consumed.
    task automatic wait_end(input int end_cyc);
        int guard = 0;
        while (cyc < end_cyc && guard < 500) begin
            tick();
            guard++;
        end
        n_checks++;
        if (sb.size() != 0 || cyc != end_cyc) begin
            n_fail++;
            $display("FAIL %s trace_drain: left %0d entries at cycle %0d, required 0 at %0d",
                     scen, sb.size(), cyc, end_cyc);
        end
    endtask

    task automatic write_coef(input int k, input logic [31:0] v);
        bus.coef_we    = 1'b1;
        bus.coef_addr  = k[2:0];
        bus.coef_wdata = v;
        shadow[k]      = v;
        tick();
        bus.coef_we    = 1'b0;
        bus.coef_wdata = $urandom;
    endtask

    task automatic check_quiet(input string tag);
        n_checks += 5;
        if (bus.signal !== 32'h0) begin
            n_fail++; $display("FAIL %s signal: got %h expected 0", tag, bus.signal);
        end
        if (bus.coeff !== 32'h0) begin
            n_fail++; $display("FAIL %s coeff: got %h expected 0", tag, bus.coeff);
        end
        if (bus.LD_result !== 1'b0) begin
            n_fail++; $display("FAIL %s LD_result: got %b expected 0", tag, bus.LD_result);
        end
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL %s busy: got %b expected 0", tag, bus.busy);
        end
        if (bus.done !== 1'b0) begin
            n_fail++; $display("FAIL %s done: got %b expected 0", tag, bus.done);
        end
    endtask

    task automatic test_reset();
        scen = "reset";
        rst_n = 1'b0;
        #12;
        check_quiet("reset_values");
        @(posedge clk_n);
        rst_n = 1'b1;
        tick();
        check_quiet("after_release");
    endtask

    task automatic test_degree2();
        int e;
        scen = "degree2";
        write_coef(2, 32'h3F80_0000);
        write_coef(1, 32'h4040_0000);
        write_coef(0, 32'h4000_0000);
        done_seen = 0;
        start_eval(2, 32'h4000_0000, e);
        wait_end(e);
        n_checks++;
        if (done_seen != 1) begin
            n_fail++; $display("FAIL degree2 done_count: got %0d expected 1", done_seen);
        end
    endtask

    task automatic test_degree0();
        int e;
        scen = "degree0";
        write_coef(0, 32'h3F80_0000);
        start_eval(0, 32'h4100_0000, e);
        wait_end(e);
    endtask

    task automatic test_degree7();
        int e;
        scen = "degree7";
        for (int k = 0; k < 8; k++) write_coef(k, 32'h1000_0000 * (k + 1) + $urandom_range(0, 255));
        done_seen = 0;
        start_eval(7, 32'hC0A0_0000, e);
        wait_end(e);
        n_checks++;
        if (done_seen != 1) begin
            n_fail++; $display("FAIL degree7 done_count: got %0d expected 1", done_seen);
        end
    endtask

    task automatic test_busy_writes();
        int e, e2, base;
        scen = "busy_writes";
        write_coef(1, 32'hAAAA_5555);
        done_seen = 0;
        base = cyc;
        start_eval(3, 32'h3FC0_0000, e);
        while (cyc < base + 20) tick();
        // Both must be ignored: the sequencer is in RUN.
        bus.coef_we    = 1'b1;
        bus.coef_addr  = 3'd1;
        bus.coef_wdata = 32'hDEAD_BEEF;
        bus.start      = 1'b1;
        bus.degree     = 3'd5;
        bus.x_in       = 32'h1234_5678;
        repeat (3) tick();
        bus.coef_we = 1'b0;
        bus.start   = 1'b0;
        wait_end(e);
        n_checks++;
        if (done_seen != 1) begin
            n_fail++; $display("FAIL busy_writes done_count: got %0d expected 1", done_seen);
        end
        // First idle cycle: write must land.
        write_coef(1, 32'h5555_AAAA);
        scen = "busy_writes_readback";
        start_eval(1, 32'h4080_0000, e2);
        wait_end(e2);
    endtask

    task automatic test_back_to_back();
        int e1, e2;
        scen = "back_to_back";
        done_seen = 0;
        start_eval(2, 32'h4000_0000, e1);
        while (cyc < e1) tick();
        start_eval(4, 32'hBF80_0000, e2);
        wait_end(e2);
        n_checks++;
        if (done_seen != 2) begin
            n_fail++; $display("FAIL back_to_back done_count: got %0d expected 2", done_seen);
        end
    endtask

    task automatic test_reset_mid_run();
        int e, base;
        scen = "reset_mid_run";
        for (int k = 0; k < 8; k++) write_coef(k, 32'hC000_0000 + k + 1);
        base = cyc;
        start_eval(5, 32'h4040_0000, e);
        while (cyc < base + 25) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_quiet("reset_async");
        sb.delete();
        done_seen = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (40) tick();
        check_quiet("reset_abort_idle");
        n_checks++;
        if (done_seen != 0) begin
            n_fail++; $display("FAIL reset_no_done: got %0d done pulses expected 0", done_seen);
        end
        for (int k = 0; k < 8; k++) shadow[k] = 32'h0;
        scen = "reset_cleared_coefs";
        start_eval(7, 32'h4000_0000, e);
        wait_end(e);
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        cyc            = 0;
        done_seen      = 0;
        bus.start      = 1'b0;
        bus.degree     = 3'd0;
        bus.x_in       = '0;
        bus.coef_we    = 1'b0;
        bus.coef_addr  = 3'd0;
        bus.coef_wdata = '0;
        for (int k = 0; k < 8; k++) shadow[k] = 32'h0;

        test_reset();
        test_degree2();
        test_degree0();
        test_degree7();
        test_busy_writes();
        test_back_to_back();
        test_reset_mid_run();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
